// File: rtl/lcd_cmd_scheduler.sv
// Command FIFO plus issue FSM in front of LCD_CTRL: one cmd_valid strobe per command,
// waits out busy (or an ack timeout), and pulses frame_done once a WRITE (cmd 0) completes.
module lcd_cmd_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [3:0]             ctrl_cmd,
  output logic                   ctrl_cmd_valid,
  input  logic                   ctrl_busy,
  input  logic                   ctrl_done,
  output logic                   frame_done,
  output logic [7:0]             cmd_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAck, StBusy, StFlush} state_e;

  state_e          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [3:0]      ctrl_cmd_q, ctrl_cmd_d;
  logic            valid_q, valid_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            zero_q, zero_d;
  logic            done_seen_q, done_seen_d;
  logic            push, pop;
  logic [3:0]      head;

  assign host_ready     = (level_q != LvlW'(DEPTH));
  assign push           = host_valid & host_ready;
  assign head           = mem_q[rd_ptr_q];
  assign ctrl_cmd       = ctrl_cmd_q;
  assign ctrl_cmd_valid = valid_q;
  assign frame_done     = frame_done_q;
  assign cmd_cnt        = cnt_q;
  assign fifo_level     = level_q;

  always_comb begin
    state_d      = state_q;
    ctrl_cmd_d   = ctrl_cmd_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    zero_d       = zero_q;
    pop          = 1'b0;
    // Only armed once a WRITE is in flight, so an early ctrl_done is remembered.
    done_seen_d  = done_seen_q | (ctrl_done & zero_q);

    unique case (state_q)
      StIdle: begin
        if (level_q != '0 && !ctrl_busy) begin
          pop        = 1'b1;
          ctrl_cmd_d = head;
          valid_d    = 1'b1;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          tmo_d      = '0;
          zero_d     = (head == 4'd0);
          if (head != 4'd0) done_seen_d = 1'b0;
          state_d    = StAck;
        end
      end
      StAck: begin
        if (ctrl_busy) begin
          state_d = StBusy;
        end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
          state_d = zero_q ? StFlush : StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StBusy: begin
        if (!ctrl_busy) state_d = zero_q ? StFlush : StIdle;
      end
      StFlush: begin
        if (done_seen_q) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          done_seen_d  = 1'b0;
          zero_d       = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = host_cmd;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) level_d = level_q + LvlW'(1);
    else if (!push && pop) level_d = level_q - LvlW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ctrl_cmd_q   <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      zero_q       <= 1'b0;
      done_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ctrl_cmd_q   <= ctrl_cmd_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      zero_q       <= zero_d;
      done_seen_q  <= done_seen_d;
    end
  end

endmodule
